// File: rtl/my_edge_pkg.sv
// Shared definitions for the edge detector bank: mode encoding and a
// constant-evaluable ceiling log2 used to size debounce counters.
package my_edge_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/my_edge_channel.sv
// One input channel: synchroniser, debounce filter, level register,
// mode-qualified edge pulse and sticky pending flag.
module my_edge_channel
  import my_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       pulse,
  output logic       level,
  output logic       pending
);

  localparam int unsigned DEB      = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_LOG  = clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W    = (CNT_LOG < 1) ? 1 : CNT_LOG;

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_out;
  logic                   accept;
  logic                   qualified;

  assign sync_out = sync[SYNC_STAGES-1];

  // The new level equals sync_out whenever accept is set, so mode is
  // qualified against sync_out rather than the pre-toggle level.
  always_comb begin
    accept    = (sync_out != level) && (cnt == CNT_W'(DEB - 1));
    qualified = 1'b0;
    if (accept) begin
      case (edge_mode_e'(mode))
        MODE_RISE: qualified = sync_out;
        MODE_FALL: qualified = ~sync_out;
        MODE_BOTH: qualified = 1'b1;
        default:   qualified = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], signal_in};

      if (sync_out == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      pulse <= qualified;

      if (qualified) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/my_edge_detector_bank.sv
// Bank of independent edge-detector channels with a shared interrupt
// formed as the OR of all pending flags.
module my_edge_detector_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   signal_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    my_edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .signal_in(signal_in[i]),
      .mode     (mode[2*i +: 2]),
      .clear    (clear[i]),
      .pulse    (pulse[i]),
      .level    (level[i]),
      .pending  (pending[i])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_my_edge_detector_bank.sv
// Self-checking bench: a default instance and a debounced instance share
// stimulus and are compared against a cycle-level behavioural model.
module tb_my_edge_detector_bank;

  localparam int CH   = 4;
  localparam int S_A  = 2;
  localparam int D_A  = 1;
  localparam int S_B  = 3;
  localparam int D_B  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH-1:0]   signal_in = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0]   clear = '0;

  logic [CH-1:0] pulse_a, level_a, pending_a;
  logic [CH-1:0] pulse_b, level_b, pending_b;
  logic          irq_a, irq_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  my_edge_detector_bank #(
    .CHANNELS(CH)
  ) dut_a (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .pulse(pulse_a), .level(level_a), .pending(pending_a), .irq(irq_a)
  );

  my_edge_detector_bank #(
    .CHANNELS(CH), .SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B)
  ) dut_b (
    .clk(clk), .rst(rst), .signal_in(signal_in), .mode(mode), .clear(clear),
    .pulse(pulse_b), .level(level_b), .pending(pending_b), .irq(irq_b)
  );

  // Behavioural model: raw input delayed by S edges, then a new level is
  // accepted once it has differed from the current level for D edges.
  logic [CH-1:0] m_lvl[2], m_pls[2], m_pend[2];
  int unsigned   m_run[2][CH];
  logic [7:0]    m_hist[2][CH];

  function automatic logic qualifies(input logic [1:0] md, input logic new_lvl);
    case (md)
      2'b01:   return new_lvl;
      2'b10:   return ~new_lvl;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lvl[d] = '0; m_pls[d] = '0; m_pend[d] = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[d][c]  = 0;
        m_hist[d][c] = '0;
      end
    end
  endtask

  task automatic model_step(input int d, input int s, input int dd);
    logic so, ev;
    for (int c = 0; c < CH; c++) begin
      so = m_hist[d][c][s-1];
      m_hist[d][c] = {m_hist[d][c][6:0], signal_in[c]};
      ev = 1'b0;
      if (so != m_lvl[d][c]) begin
        m_run[d][c] = m_run[d][c] + 1;
        if (m_run[d][c] >= dd) begin
          m_lvl[d][c] = so;
          m_run[d][c] = 0;
          ev = qualifies(mode[2*c +: 2], so);
        end
      end else begin
        m_run[d][c] = 0;
      end
      m_pls[d][c] = ev;
      if (ev) m_pend[d][c] = 1'b1;
      else if (clear[c]) m_pend[d][c] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        model_step(0, S_A, D_A);
        model_step(1, S_B, D_B);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; signal_in = '0; clear = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pulse_a, level_a, pending_a, irq_a} !== '0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {pulse_a, level_a, pending_a, irq_a});
    end
    checks++;
    if ({pulse_b, level_b, pending_b, irq_b} !== '0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", {pulse_b, level_b, pending_b, irq_b});
    end
  endtask

  task automatic test_rise_latency();
    logic ep, el;
    do_reset();
    mode = 8'b01_01_01_01;
    signal_in[0] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      ep = (n == 3); el = (n >= 3);
      checks++;
      if (pulse_a[0] !== ep) begin failures++; $display("FAIL rise_pulse n=%0d got=%b exp=%b", n, pulse_a[0], ep); end
      checks++;
      if (level_a[0] !== el) begin failures++; $display("FAIL rise_level n=%0d got=%b exp=%b", n, level_a[0], el); end
      checks++;
      if ({pending_a[0], irq_a} !== {el, el}) begin
        failures++; $display("FAIL rise_pending n=%0d got=%b%b exp=%b%b", n, pending_a[0], irq_a, el, el);
      end
    end
    signal_in[0] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checks++;
      if (pulse_a[0] !== 1'b0 || level_a[0] !== (n < 3)) begin
        failures++; $display("FAIL fall_ignored n=%0d pulse=%b level=%b exp pulse=0 level=%b", n, pulse_a[0], level_a[0], (n < 3));
      end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    mode = 8'hFF;
    signal_in[0] = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 3) signal_in[0] = 1'b0;
      checks++;
      if (level_b[0] !== 1'b0 || pulse_b[0] !== 1'b0) begin
        failures++; $display("FAIL glitch n=%0d level=%b pulse=%b exp 0 0", n, level_b[0], pulse_b[0]);
      end
    end
    for (int dir = 1; dir >= 0; dir--) begin
      signal_in[0] = dir[0];
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        checks++;
        if (level_b[0] !== ((n >= 7) ? dir[0] : ~dir[0]) || pulse_b[0] !== (n == 7)) begin
          failures++;
          $display("FAIL debounce dir=%0d n=%0d level=%b pulse=%b exp level=%b pulse=%b",
                   dir, n, level_b[0], pulse_b[0], ((n >= 7) ? dir[0] : ~dir[0]), (n == 7));
        end
      end
    end
  endtask

  task automatic test_modes();
    int falls;
    falls = 0;
    do_reset();
    mode = 8'b00_00_10_00;
    for (int n = 0; n < 40; n++) begin
      signal_in[2:1] = ((n / 4) % 2 == 1) ? 2'b11 : 2'b00;
      @(negedge clk);
      checks++;
      if ({pulse_a, level_a, pending_a, irq_a} !== {m_pls[0], m_lvl[0], m_pend[0], |m_pend[0]}) begin
        failures++;
        $display("FAIL modes_model n=%0d got=%h exp=%h", n, {pulse_a, level_a, pending_a, irq_a},
                 {m_pls[0], m_lvl[0], m_pend[0], |m_pend[0]});
      end
      checks++;
      if (pulse_a[2] !== 1'b0 || pending_a[2] !== 1'b0) begin
        failures++; $display("FAIL mode_off n=%0d pulse=%b pending=%b exp 0 0", n, pulse_a[2], pending_a[2]);
      end
      checks++;
      if (pulse_a[1] === 1'b1 && level_a[1] !== 1'b0) begin
        failures++; $display("FAIL mode_fall_dir n=%0d level=%b exp 0", n, level_a[1]);
      end
      if (pulse_a[1] === 1'b1) falls++;
    end
    checks++;
    if (falls != 4) begin failures++; $display("FAIL fall_count got=%0d exp=4", falls); end
  endtask

  task automatic test_pending_clear();
    do_reset();
    mode = 8'b00_00_00_11;
    signal_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pending_a[0] !== 1'b1) begin failures++; $display("FAIL pend_set got=%b exp=1", pending_a[0]); end
    signal_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    clear[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({pulse_a[0], pending_a[0]} !== 2'b11) begin
      failures++; $display("FAIL set_wins got=%b%b exp=11", pulse_a[0], pending_a[0]);
    end
    @(negedge clk);
    checks++;
    if ({pending_a[0], irq_a} !== 2'b00) begin
      failures++; $display("FAIL clear got=%b%b exp=00", pending_a[0], irq_a);
    end
    @(negedge clk);
    checks++;
    if ({pending_a, irq_a} !== '0) begin
      failures++; $display("FAIL clear_idle got=%h exp=0", {pending_a, irq_a});
    end
    clear[0] = 1'b0;
  endtask

  task automatic test_through_reset();
    rst = 1'b0; signal_in = '1; mode = 8'h55; clear = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pulse_a, pulse_b, irq_a, irq_b} !== '0) begin
      failures++; $display("FAIL held_in_reset got=%h exp=0", {pulse_a, pulse_b, irq_a, irq_b});
    end
    rst = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      checks++;
      if (pulse_a !== ((n == 3) ? 4'hF : 4'h0)) begin
        failures++; $display("FAIL release_a n=%0d got=%h exp=%h", n, pulse_a, ((n == 3) ? 4'hF : 4'h0));
      end
      checks++;
      if (pulse_b !== ((n == 7) ? 4'hF : 4'h0)) begin
        failures++; $display("FAIL release_b n=%0d got=%h exp=%h", n, pulse_b, ((n == 7) ? 4'hF : 4'h0));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 8'hFF;
    signal_in = 4'b0001;
    repeat (2) @(negedge clk);
    signal_in = 4'b0011;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (pulse_a !== 4'b0010 || level_b !== 4'b0000) begin
      failures++; $display("FAIL pre_async pulse_a=%b level_b=%b exp 0010 0000", pulse_a, level_b);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pulse_a, level_a, pending_a, irq_a, pulse_b, level_b, pending_b, irq_b} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {pulse_a, level_a, pending_a, irq_a, pulse_b, level_b, pending_b, irq_b});
    end
    signal_in = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      checks++;
      if ({pulse_a, pulse_b, irq_a, irq_b} !== '0) begin
        failures++; $display("FAIL stale_after_reset n=%0d got=%h exp=0", n, {pulse_a, pulse_b, irq_a, irq_b});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(19) == 0) mode = 8'($urandom);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(4) == 0) signal_in[c] = ~signal_in[c];
        clear[c] = ($urandom_range(7) == 0);
      end
      @(negedge clk);
      checks++;
      if ({pulse_a, level_a, pending_a, irq_a} !== {m_pls[0], m_lvl[0], m_pend[0], |m_pend[0]}) begin
        failures++;
        $display("FAIL random_a n=%0d got=%h exp=%h", n, {pulse_a, level_a, pending_a, irq_a},
                 {m_pls[0], m_lvl[0], m_pend[0], |m_pend[0]});
      end
      checks++;
      if ({pulse_b, level_b, pending_b, irq_b} !== {m_pls[1], m_lvl[1], m_pend[1], |m_pend[1]}) begin
        failures++;
        $display("FAIL random_b n=%0d got=%h exp=%h", n, {pulse_b, level_b, pending_b, irq_b},
                 {m_pls[1], m_lvl[1], m_pend[1], |m_pend[1]});
      end
    end
    clear = '0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_debounce();
    test_modes();
    test_pending_clear();
    test_through_reset();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
